// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the button front end: hold FSM encodings and default timings in ms.
// Also provides the counter width helper used by every channel.
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEATING = 2'd2
  } hold_state_e;

  localparam int DEF_N_BTN       = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_STABLE_MS   = 20;
  localparam int DEF_HOLD_MS     = 1000;
  localparam int DEF_REPEAT_MS   = 200;

  // Bits needed to count 0..max_val-1, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: synchroniser, stable-time debounce and hold-to-repeat FSM; all outputs registered.
// Edge to level/pulse latency is SYNC_STAGES+STABLE_MS cycles; no backpressure, pulses are fire-and-forget.
module btn_channel
  import btn_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_MS   = DEF_STABLE_MS,
  parameter int HOLD_MS     = DEF_HOLD_MS,
  parameter int REPEAT_MS   = DEF_REPEAT_MS
) (
  input  logic clk_1khz,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int DB_W     = $clog2(STABLE_MS + 1);
  localparam int HOLD_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int HC_W     = cnt_width(HOLD_MAX);
  localparam bit REPEAT_EN = (REPEAT_MS != 0);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(STABLE_MS - 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_MS - 1);
  localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REPEAT_EN ? REPEAT_MS - 1 : 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [DB_W-1:0]        dbcnt_q;
  logic                   flip;
  logic                   rise;
  logic                   fall;

  hold_state_e            state_q, state_d;
  logic [HC_W-1:0]        hcnt_q, hcnt_d;
  logic                   rpt_d;

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // The level flips on the edge where the counter would reach STABLE_MS, so the
  // pulse and the new level appear together and the hold FSM reacts on that edge.
  assign flip = (sync_s != btn_level) && (dbcnt_q == DB_LAST);
  assign rise = flip && sync_s;
  assign fall = flip && !sync_s;

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      dbcnt_q     <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= rise;
      btn_release <= fall;
      if (sync_s == btn_level) begin
        dbcnt_q <= '0;
      end else if (flip) begin
        btn_level <= sync_s;
        dbcnt_q   <= '0;
      end else begin
        dbcnt_q <= dbcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      state_q    <= RELEASED;
      hcnt_q     <= '0;
      btn_repeat <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      btn_repeat <= rpt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    rpt_d   = 1'b0;
    case (state_q)
      RELEASED: begin
        if (rise) begin
          hcnt_d  = '0;
          state_d = HOLD_WAIT;
        end
      end
      HOLD_WAIT: begin
        if (hcnt_q == HOLD_LAST) begin
          rpt_d   = 1'b1;
          hcnt_d  = '0;
          state_d = REPEATING;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      REPEATING: begin
        // With repeats disabled the counter parks here until release.
        if (REPEAT_EN) begin
          if (hcnt_q == REP_LAST) begin
            rpt_d  = 1'b1;
            hcnt_d = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = RELEASED;
        hcnt_d  = '0;
      end
    endcase
    // Release overrides any repeat falling due on the same edge.
    if (fall) begin
      state_d = RELEASED;
      hcnt_d  = '0;
      rpt_d   = 1'b0;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// N_BTN independent button channels feeding the mode/set control FSM; all outputs registered.
// Latency SYNC_STAGES+STABLE_MS cycles from a clean pin edge; no backpressure.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int N_BTN       = DEF_N_BTN,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_MS   = DEF_STABLE_MS,
  parameter int HOLD_MS     = DEF_HOLD_MS,
  parameter int REPEAT_MS   = DEF_REPEAT_MS
) (
  input  logic             clk_1khz,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_MS   (STABLE_MS),
      .HOLD_MS     (HOLD_MS),
      .REPEAT_MS   (REPEAT_MS)
    ) u_ch (
      .clk_1khz    (clk_1khz),
      .rst         (rst),
      .btn_raw     (btn_in[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_repeat  (btn_repeat[i])
    );
  end

endmodule
